// File: rtl/pe_types.sv
// Types shared by the PE, its switchbox and FUs: the packet word and the
// port direction used at PE level to steer grants into per-port buffers.
package pe_types;

   localparam int PKT_W = 8;
   localparam int PORTS = 4;

   typedef logic [PKT_W-1:0] pkt_t;

   typedef enum logic [1:0] {
      PORT_N = 2'd0,
      PORT_E = 2'd1,
      PORT_S = 2'd2,
      PORT_W = 2'd3
   } port_dir_t;

endpackage

// File: rtl/pe_ingress_buffer.sv
// Per-port circular ingress FIFO: head/empty go to the PE arbiter, each real
// dequeue returns one credit upstream, bad traffic sets sticky error flags.
module pe_ingress_buffer
   import pe_types::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  pkt_t          in_pkt,
   output logic          credit_ret,
   input  logic          deq,
   output logic          empty,
   output pkt_t          head_pkt,
   output logic [CW-1:0] occupancy,
   output logic          overflow_err,
   output logic          underflow_err
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   pkt_t          mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          credit_ret_q, credit_ret_d;
   logic          overflow_err_q, overflow_err_d;
   logic          underflow_err_q, underflow_err_d;
   logic          deq_ok, enq_ok;

   always_comb begin
      deq_ok          = deq && (count_q != '0);
      // A full buffer still accepts when the head leaves in the same cycle.
      enq_ok          = in_valid && ((count_q != DEPTH_C) || deq_ok);
      wr_ptr_d        = enq_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d        = deq_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d         = count_q;
      case ({enq_ok, deq_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      credit_ret_d    = deq_ok;
      overflow_err_d  = overflow_err_q | (in_valid && !enq_ok);
      underflow_err_d = underflow_err_q | (deq && (count_q == '0));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         credit_ret_q    <= 1'b0;
         overflow_err_q  <= 1'b0;
         underflow_err_q <= 1'b0;
      end else begin
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         count_q         <= count_d;
         credit_ret_q    <= credit_ret_d;
         overflow_err_q  <= overflow_err_d;
         underflow_err_q <= underflow_err_d;
      end
   end

   // Storage is deliberately left unreset; count gates everything read from it.
   always_ff @(posedge clk) begin
      if (!rst && enq_ok) mem_q[wr_ptr_q] <= in_pkt;
   end

   assign empty         = (count_q == '0);
   assign head_pkt      = empty ? '0 : mem_q[rd_ptr_q];
   assign occupancy     = count_q;
   assign credit_ret    = credit_ret_q;
   assign overflow_err  = overflow_err_q;
   assign underflow_err = underflow_err_q;

   a_count_bound : assert property (@(posedge clk) count_q <= DEPTH_C);
   a_no_credit_after_rst : assert property (@(posedge clk) $fell(rst) |-> !credit_ret_q);

endmodule

// File: tb/tb_pe_ingress_buffer.sv
// Self-checking bench for pe_ingress_buffer: directed scenarios plus random
// traffic, compared each cycle against a queue-based model of the buffer.
module tb_pe_ingress_buffer;
   import pe_types::*;

   localparam int DEPTH = 4;
   localparam int CW = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   pkt_t          in_pkt;
   logic          credit_ret;
   logic          deq;
   logic          empty;
   pkt_t          head_pkt;
   logic [CW-1:0] occupancy;
   logic          overflow_err;
   logic          underflow_err;

   int checks = 0;
   int errors = 0;

   // Model state: plain queue of stored packets plus expected flags.
   pkt_t m_q[$];
   bit   m_credit, m_ovf, m_unf;

   pe_ingress_buffer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_pkt(in_pkt),
      .credit_ret(credit_ret), .deq(deq), .empty(empty), .head_pkt(head_pkt),
      .occupancy(occupancy), .overflow_err(overflow_err), .underflow_err(underflow_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit removed, accepted;
      if (rst) begin
         m_q.delete();
         m_credit = 0;
         m_ovf    = 0;
         m_unf    = 0;
      end else begin
         removed  = deq && (m_q.size() > 0);
         accepted = in_valid && ((m_q.size() < DEPTH) || removed);
         if (deq && m_q.size() == 0) m_unf = 1;
         if (in_valid && !accepted) m_ovf = 1;
         if (removed) void'(m_q.pop_front());
         if (accepted) m_q.push_back(in_pkt);
         m_credit = removed;
      end
   endtask

   task automatic compare_all();
      chk("cmp_empty", 32'(empty), 32'(m_q.size() == 0));
      chk("cmp_head", 32'(head_pkt), (m_q.size() == 0) ? 32'd0 : 32'(m_q[0]));
      chk("cmp_occ", 32'(occupancy), 32'(m_q.size()));
      chk("cmp_credit", 32'(credit_ret), 32'(m_credit));
      chk("cmp_ovf", 32'(overflow_err), 32'(m_ovf));
      chk("cmp_unf", 32'(underflow_err), 32'(m_unf));
   endtask

   // One clock: DUT and model both sample the current inputs at the edge,
   // outputs are compared 1 time unit later.
   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic drive(input logic v, input pkt_t p, input logic d);
      in_valid = v;
      in_pkt   = p;
      deq      = d;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, '0, 1'b0);
      cycle();
      cycle();
      rst = 1'b0;
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_occ", 32'(occupancy), 32'd0);
      chk("rst_head", 32'(head_pkt), 32'd0);
      chk("rst_errs", {30'd0, overflow_err, underflow_err}, 32'd0);

      // Fill
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, pkt_t'(8'hA0 + i), 1'b0);
         cycle();
         chk("fill_occ", 32'(occupancy), 32'(i + 1));
         chk("fill_empty", 32'(empty), 32'd0);
         chk("fill_head", 32'(head_pkt), 32'hA0);
      end

      // Full with simultaneous enqueue and dequeue
      drive(1'b1, 8'hB0, 1'b1);
      cycle();
      chk("simul_occ", 32'(occupancy), 32'd4);
      chk("simul_head", 32'(head_pkt), 32'hA1);
      chk("simul_credit", 32'(credit_ret), 32'd1);
      chk("simul_ovf", 32'(overflow_err), 32'd0);

      // Overflow
      drive(1'b1, 8'hCC, 1'b0);
      cycle();
      chk("ovf_flag", 32'(overflow_err), 32'd1);
      chk("ovf_occ", 32'(occupancy), 32'd4);
      chk("ovf_credit", 32'(credit_ret), 32'd0);
      chk("model_pin_size", 32'(m_q.size()), 32'd4);

      // Drain: expect A1, A2, A3, B0; 0xCC must never appear
      begin
         logic [7:0] exp_seq [4];
         exp_seq = '{8'hA1, 8'hA2, 8'hA3, 8'hB0};
         for (int i = 0; i < 4; i++) begin
            chk("drain_head", 32'(head_pkt), 32'(exp_seq[i]));
            drive(1'b0, '0, 1'b1);
            cycle();
            chk("drain_credit", 32'(credit_ret), 32'd1);
         end
      end
      chk("drain_empty", 32'(empty), 32'd1);
      chk("drain_head0", 32'(head_pkt), 32'd0);
      chk("drain_ovf_hold", 32'(overflow_err), 32'd1);
      drive(1'b0, '0, 1'b0);
      cycle();
      chk("idle_credit", 32'(credit_ret), 32'd0);

      // Underflow with concurrent enqueue
      drive(1'b1, 8'hD0, 1'b1);
      cycle();
      chk("unf_flag", 32'(underflow_err), 32'd1);
      chk("unf_credit", 32'(credit_ret), 32'd0);
      chk("unf_head", 32'(head_pkt), 32'hD0);
      chk("unf_occ", 32'(occupancy), 32'd1);

      // Interleaved traffic across pointer wrap
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, pkt_t'(8'h10 + i), i[0]);
         cycle();
      end
      drive(1'b0, '0, 1'b1);
      while (occupancy > 3) cycle();
      drive(1'b0, '0, 1'b0);
      chk("pre_rst_occ", 32'(occupancy), 32'd3);

      // Mid-run reset
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("midrst_empty", 32'(empty), 32'd1);
      chk("midrst_occ", 32'(occupancy), 32'd0);
      chk("midrst_errs", {30'd0, overflow_err, underflow_err}, 32'd0);
      cycle();
      chk("midrst_credit", 32'(credit_ret), 32'd0);

      // Random traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         drive($urandom_range(0, 99) < 60, pkt_t'($urandom), $urandom_range(0, 99) < 50);
         cycle();
      end
      rst = 1'b0;
      drive(1'b0, '0, 1'b0);
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
